// File: rtl/pipe_rr_arbiter.sv
// Round-robin arbiter that shares one downstream DOR/DIR/ack stage between NUM_REQ producers.
// Optional watchdog on a stalled consumer: define ARB_TIMEOUT_EN.
module pipe_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_dor,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic                       out_dir,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ack_in,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_err
);
  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RELEASE} state_t;

  state_t             r_state, w_state_nxt;
  logic [IDW-1:0]     r_rr_ptr, r_grant_id, w_sel, w_ptr_inc;
  logic [NUM_REQ-1:0] r_req_ack;
  logic [WIDTH-1:0]   r_out_data, w_sel_data;
  logic               r_out_dir, r_tmo_err;
  logic               w_any, w_go, w_done, w_tmo;

  // First requester at or above rr_ptr, wrapping; scan downward so the nearest one wins.
  always_comb begin
    int idx;
    w_any = 1'b0;
    w_sel = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_dor[IDW'(idx)]) begin
        w_any = 1'b1;
        w_sel = IDW'(idx);
      end
    end
  end

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (w_sel == IDW'(i)) w_sel_data = req_data[i*WIDTH +: WIDTH];
  end

  assign w_ptr_inc = (r_grant_id == IDW'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tmo_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  r_tmo_cnt <= '0;
    else if (w_go)               r_tmo_cnt <= '0;
    else if (r_state == S_GRANT) r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT > 0);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_go        = 1'b0;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      S_IDLE: if (w_any) begin
        w_go        = 1'b1;
        w_state_nxt = S_GRANT;
      end
      S_GRANT: begin
        if (out_ack_in) begin
          w_done      = 1'b1;
          w_state_nxt = S_RELEASE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (r_tmo_cnt == TW'(TIMEOUT - 1)) begin
          w_tmo       = 1'b1;
          w_state_nxt = S_IDLE;
        end
`endif
      end
      S_RELEASE: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // req_ack defaults low every cycle, which makes the ack a single-cycle pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_req_ack  <= '0;
      r_out_dir  <= 1'b0;
      r_out_data <= '0;
      r_grant_id <= '0;
      r_rr_ptr   <= '0;
      r_tmo_err  <= 1'b0;
    end else begin
      r_req_ack <= '0;
      if (w_go) begin
        r_grant_id <= w_sel;
        r_out_data <= w_sel_data;
        r_out_dir  <= 1'b1;
      end
      if (w_done) begin
        r_out_dir <= 1'b0;
        r_req_ack <= NUM_REQ'(1) << r_grant_id;
        r_rr_ptr  <= w_ptr_inc;
      end
      if (w_tmo) begin
        r_out_dir <= 1'b0;
        r_tmo_err <= 1'b1;
        r_rr_ptr  <= w_ptr_inc;
      end
    end
  end

  assign req_ack     = r_req_ack;
  assign out_dir     = r_out_dir;
  assign out_data    = r_out_data;
  assign grant_id    = r_grant_id;
  assign busy        = (r_state != S_IDLE);
  assign timeout_err = r_tmo_err;

endmodule

// File: doc/pipe_rr_arbiter.md
Name: pipe_rr_arbiter

Overview:
- Round-robin arbiter that shares one downstream pipeline stage between NUM_REQ upstream producer stages.
- Uses the pipeline DOR/DIR/ack handshake on both sides, so it drops in between existing stages without changing them.
- Latches the granted producer's data, presents it downstream with DIR, waits for the consumer's ack, then acks the producer.

Parameters:
- NUM_REQ, 4, number of upstream requesters (2..8).
- WIDTH, 8, data width.
- TIMEOUT, 255, watchdog limit in cycles; used only with ARB_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- req_dor  input  NUM_REQ  per-producer data-output-ready.
- req_data  input  NUM_REQ*WIDTH  producer data, flattened; requester i occupies bits [i*WIDTH +: WIDTH].
- req_ack  output  NUM_REQ  per-producer ack, one-cycle pulse.
- out_dir  output  1  data-input-ready to the consumer.
- out_data  output  WIDTH  data to the consumer.
- out_ack_in  input  1  ack from the consumer.
- grant_id  output  $clog2(NUM_REQ)  index of the current or last grant.
- busy  output  1  high when state != IDLE.
- timeout_err  output  1  sticky watchdog flag; tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; req_ack=0; out_dir=0; out_data=0; grant_id=0; rr_ptr=0; timeout_err=0.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - If any req_dor bit is set, select the first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - At that edge: grant_id<=sel; out_data<=req_data slice sel; out_dir<=1; state<=GRANT.
  - Latency: DOR sampled at edge n gives out_dir=1 visible after edge n.
  - With no request, stay in IDLE with outputs held.
- GRANT:
  - out_dir and out_data are held stable.
  - When out_ack_in=1 is sampled: out_dir<=0; req_ack[grant_id]<=1; rr_ptr<=(grant_id+1) mod NUM_REQ; state<=RELEASE.
  - Otherwise stay in GRANT indefinitely (no timeout unless the macro is enabled).
- RELEASE:
  - req_ack<=0, so the ack is exactly one cycle wide.
  - state<=IDLE.
  - This extra cycle lets the producer drop DOR before it is re-sampled, so a producer is never granted twice for one transfer.
- Fairness: a granted requester has lowest priority on the next arbitration.
  - All four requesting continuously (NUM_REQ=4) gives grant order 0,1,2,3,0,...
- Throughput: at most one transfer per 3 cycles (IDLE, GRANT with immediate ack, RELEASE).
- Data: captured once at grant. Later changes on req_data are ignored until the next grant.
- req_dor dropped during GRANT: the transfer still completes and the producer still gets its ack. No error is flagged.
- out_ack_in while in IDLE or RELEASE: ignored.
- grant_id keeps its last value in IDLE.
- Reset mid-GRANT: immediate return to IDLE with out_dir=0 and no ack issued. rr_ptr returns to 0.
- Width rule: rr_ptr increment wraps at NUM_REQ, not at a power of two.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to GRANT and increments each cycle spent in GRANT.
  - When it reaches TIMEOUT with no ack: out_dir<=0; timeout_err<=1 (sticky until reset); rr_ptr advances past grant_id; state<=IDLE.
  - No req_ack is issued, so the producer keeps DOR asserted and is re-arbitrated later.
- Undefined: no counter; timeout_err is tied 0; GRANT waits indefinitely.

Test Plan:
- Single request: req_dor=4'b0100, req_data[2]=8'h5A, consumer acks 1 cycle after out_dir -> out_dir=1 with out_data=8'h5A one cycle after DOR; grant_id=2; req_ack=4'b0100 for exactly one cycle; busy low again 3 cycles after the grant edge.
- Round robin: req_dor=4'b1111 held, each producer drops DOR on its ack then reasserts -> grant sequence 0,1,2,3,0,1 with no requester granted twice in a row.
- Consumer stall: out_ack_in held 0 for 6 cycles -> out_dir and out_data are stable for all 6 cycles; req_ack stays 0 until the cycle after out_ack_in=1.
- Data change after grant: req_data[1] changes from 8'h11 to 8'h22 during GRANT -> out_data stays 8'h11.
- Reset mid-GRANT: reset pulled low asynchronously while out_dir=1 -> out_dir, req_ack and busy are 0 immediately. After release, with req_dor=4'b0011 the first grant is 0.
- ARB_TIMEOUT_EN with TIMEOUT=10 and no consumer ack -> out_dir drops after 10 GRANT cycles; timeout_err=1; req_ack never pulses; the next grant goes to the next requesting index.
